// File: rtl/pspin_stdout_fifo_if.sv
`default_nettype none
// ============================================================================
// pspin_stdout_fifo_if : cluster character streams in, tagged head word out
// Revision: 1.0
// ============================================================================
interface pspin_stdout_fifo_if #(
  parameter int NUM_CLUSTERS  = 2,
  parameter int CORE_ID_WIDTH = 4,
  parameter int DEPTH         = 1024
);
  logic [NUM_CLUSTERS-1:0]               in_valid;
  logic [NUM_CLUSTERS-1:0]               in_ready;
  logic [8*NUM_CLUSTERS-1:0]             in_char;
  logic [CORE_ID_WIDTH*NUM_CLUSTERS-1:0] in_core_id;
  logic [31:0]                           stdout_dout;
  logic                                  stdout_data_valid;
  logic                                  stdout_rd_en;
  logic [$clog2(DEPTH):0]                fill_level;

  modport slave (
    input  in_valid, in_char, in_core_id, stdout_rd_en,
    output in_ready, stdout_dout, stdout_data_valid, fill_level
  );

  modport master (
    output in_valid, in_char, in_core_id, stdout_rd_en,
    input  in_ready, stdout_dout, stdout_data_valid, fill_level
  );
endinterface
`default_nettype wire

// File: rtl/pspin_stdout_fifo.sv
`default_nettype none
// ============================================================================
// pspin_stdout_fifo : round-robin stdout collector with show-ahead FIFO output
// Revision: 1.0
// ============================================================================
module pspin_stdout_fifo #(
  parameter int NUM_CLUSTERS  = 2,
  parameter int CORE_ID_WIDTH = 4,
  parameter int DEPTH         = 1024
) (
  input wire logic           clk,
  input wire logic           rst,
  pspin_stdout_fifo_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int RRW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam logic [AW:0] c_full_lvl = (AW+1)'(DEPTH);

  logic [RRW-1:0]          r_rr_ptr;
  logic [RRW-1:0]          w_winner;
  logic                    w_found;
  logic [NUM_CLUSTERS-1:0] w_ready;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_ram_empty;
  logic                    w_load;
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_wr_ptr_vis;
  logic [AW:0]             r_rd_ptr;
  logic [AW:0]             r_fill;
  logic [31:0]             r_dout;
  logic                    r_dv;
  logic [7:0]              w_cl_field;
  logic [7:0]              w_core_field;
  logic [7:0]              w_char;
  logic [31:0]             w_word;
  logic [31:0]             r_mem [DEPTH];

  // Round-robin search: first valid port at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_CLUSTERS; k++) begin
      if (!w_found && bus.in_valid[(int'(r_rr_ptr) + k) % NUM_CLUSTERS]) begin
        w_found  = 1'b1;
        w_winner = RRW'((int'(r_rr_ptr) + k) % NUM_CLUSTERS);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_found && (r_fill < c_full_lvl) && !rst) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_cl_field                      = '0;
    w_cl_field[RRW-1:0]             = w_winner;
    w_core_field                    = '0;
    w_core_field[CORE_ID_WIDTH-1:0] = bus.in_core_id[int'(w_winner)*CORE_ID_WIDTH +: CORE_ID_WIDTH];
    w_char                          = bus.in_char[int'(w_winner)*8 +: 8];
    w_word                          = {w_cl_field, w_core_field, 8'h00, w_char};
  end

  assign w_push = |(bus.in_valid & w_ready);
  assign w_pop  = r_dv & bus.stdout_rd_en;

  // Reads compare against a one-cycle-delayed write pointer, so a word is
  // never read on the edge that writes it and first-word latency is two edges.
  assign w_ram_empty = (r_rd_ptr == r_wr_ptr_vis);
  assign w_load      = !r_dv && !w_ram_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_wr_ptr_vis <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_dout       <= '0;
      r_dv         <= 1'b0;
    end else begin
      r_wr_ptr_vis <= r_wr_ptr;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (int'(w_winner) == NUM_CLUSTERS - 1) ? '0 : w_winner + 1'b1;
      end
      if (w_load) begin
        r_dout   <= r_mem[r_rd_ptr[AW-1:0]];
        r_dv     <= 1'b1;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else if (w_pop) begin
        r_dv <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign bus.in_ready          = w_ready;
  assign bus.stdout_dout       = r_dout;
  assign bus.stdout_data_valid = r_dv;
  assign bus.fill_level        = r_fill;
endmodule
`default_nettype wire

// File: doc/pspin_stdout_fifo.md
Name: pspin_stdout_fifo

Overview:
- Collects stdout characters emitted by the PsPIN clusters (printf path) and buffers them for host readout.
- Arbitrates round-robin among per-cluster character streams, tags each character with its cluster/core origin and stores it in a FIFO.
- Presents the head word show-ahead on the stdout_dout / stdout_data_valid / stdout_rd_en interface consumed by the control-register block (stdout FIFO register, 0x1000).

Parameters:
- NUM_CLUSTERS, 2, number of cluster input ports (1..8)
- CORE_ID_WIDTH, 4, width of per-cluster core id field (≤8)
- DEPTH, 1024, total word capacity including output register; power of two, ≥4

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  NUM_CLUSTERS  per-cluster character valid
- in_ready  out  NUM_CLUSTERS  per-cluster accept; at most one bit high per cycle
- in_char  in  8*NUM_CLUSTERS  character, cluster i at [8i+:8]
- in_core_id  in  CORE_ID_WIDTH*NUM_CLUSTERS  emitting core, cluster i at [CORE_ID_WIDTH*i+:CORE_ID_WIDTH]
- stdout_dout  out  32  head word
- stdout_data_valid  out  1  stdout_dout holds a valid word
- stdout_rd_en  in  1  pop head word
- fill_level  out  $clog2(DEPTH)+1  words held (RAM + output register)

Behaviour:
- Reset (async assert, sync release): in_ready=0, stdout_dout=0, stdout_data_valid=0, fill_level=0, pointers=0, round-robin pointer=0. Contents are discarded. A reset mid-stream drops all buffered words and any in-flight handshake.
- Word format: [31:24]=cluster index, [23:16]=core id zero-extended, [15:8]=0, [7:0]=char.
- Arbitration:
  - Combinational grant, round-robin starting at index rr_ptr.
  - Lowest index ≥ rr_ptr (wrapping) with in_valid set wins.
  - in_ready[winner]=1 only if fill_level<DEPTH.
  - On handshake, rr_ptr ← winner+1 mod NUM_CLUSTERS; otherwise rr_ptr holds.
  - in_ready is only asserted for a valid port. Senders must hold in_valid/data until ready.
- Storage:
  - Accepted word is written to the RAM at wr_ptr.
  - Pointers carry one extra wrap bit; wrap is modulo DEPTH.
- Output stage (registered, show-ahead):
  - When stdout_data_valid=0 and the RAM is non-empty, the word at rd_ptr loads into stdout_dout on the next edge. stdout_data_valid→1 and rd_ptr advances.
  - Latency: a handshake at edge E into an empty FIFO gives stdout_data_valid=1 after edge E+2.
- Pop:
  - stdout_rd_en=1 with stdout_data_valid=1 at an edge consumes the head word. stdout_data_valid→0 after that edge.
  - If more words remain, the next word appears after the following edge. This one-cycle bubble is required and is not optimised away.
  - stdout_rd_en with stdout_data_valid=0 is ignored: no state change.
  - stdout_dout keeps its last value after a pop until overwritten.
- fill_level:
  - Increments on handshake, decrements on an effective pop.
  - Unchanged when both occur in the same cycle.
  - Registered, updated at the same edge as the events.
- Full: at fill_level==DEPTH all in_ready=0. A same-cycle pop does not open acceptance that cycle; acceptance resumes the cycle after fill_level drops.
- No drops, no overflow/underflow possible; no error outputs.

Test Plan:
- Single char: cluster 1 sends 'A' (0x41) core 3 at edge E → stdout_data_valid=1 after E+2, stdout_dout=0x01030041, fill_level=1; pulse stdout_rd_en → data_valid=0, fill_level=0.
- Fairness: both clusters hold in_valid continuously, chars 0x10.. and 0x20.. → grants alternate 0,1,0,1; readout order 0x10,0x20,0x11,0x21; never two in_ready bits high.
- Full (DEPTH=4): push 5 chars from cluster 0 with no pops → in_ready[0]=0 after 4 accepts, fill_level=4. One pop → 5th char accepted the following cycle, final readout order intact.
- Pop on empty: stdout_rd_en pulsed with FIFO empty → data_valid stays 0, fill_level stays 0, pointers unchanged; a subsequent push reads back correctly.
- Simultaneous push/pop at fill_level=2 → fill_level stays 2; back-to-back pops show one-cycle valid bubble between words.
- Async reset asserted mid-stream between edges with 3 words buffered → outputs zero immediately (before the next edge); after release, fill_level=0, new char reads back first.
